// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH,
        PARITY
    } rx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic int unsigned half_bit(input int unsigned ovs);
        return ovs / 2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, parallel word and strobes out.
// RX_PERR exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if #(
    parameter int unsigned SIZE = 8
);
    logic            RXD;
    logic [SIZE-1:0] RXDATA;
    logic            RX_VALID;
    logic            RX_BUSY;
    logic            RX_FERR;
`ifdef UART_RX_PARITY_EN
    logic            RX_PERR;
`endif

    modport master (
        output RXD,
        input  RXDATA,
        input  RX_VALID,
        input  RX_BUSY,
`ifdef UART_RX_PARITY_EN
        input  RX_PERR,
`endif
        input  RX_FERR
    );

    modport slave (
        input  RXD,
        output RXDATA,
        output RX_VALID,
        output RX_BUSY,
`ifdef UART_RX_PARITY_EN
        output RX_PERR,
`endif
        output RX_FERR
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle-high line never looks like a start bit after reset.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start / SIZE data bits LSB first / stop, mid-bit sampled.
// Define UART_RX_PARITY_EN to add a parity bit, PARITY_ODD and the RX_PERR strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SIZE = 8,
    parameter int unsigned OVS  = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic RXC,
    input  logic R,
    uart_rx_if.slave bus
);

    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned BW = $clog2(SIZE) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(half_bit(OVS) - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SIZE - 1);

    logic            w_rxs;
    rx_state_t       r_state, w_state_d;
    logic [TW-1:0]   r_tick, w_tick_d;
    logic [BW-1:0]   r_bit, w_bit_d;
    logic [SIZE-1:0] r_shift, w_shift_d;
    logic [SIZE-1:0] r_data, w_data_d;
    logic            r_valid, w_valid_d;
    logic            r_ferr, w_ferr_d;
    logic            w_good;
`ifdef UART_RX_PARITY_EN
    logic            r_perr, w_perr_d;
    logic            r_perr_pend, w_perr_pend_d;
`endif

    uart_rx_sync u_sync (
        .i_clk (RXC),
        .i_rst (R),
        .i_d   (bus.RXD),
        .o_q   (w_rxs)
    );

    always_ff @(posedge RXC) begin
        if (R) begin
            r_state     <= IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr      <= 1'b0;
            r_perr_pend <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_tick      <= w_tick_d;
            r_bit       <= w_bit_d;
            r_shift     <= w_shift_d;
            r_data      <= w_data_d;
            r_valid     <= w_valid_d;
            r_ferr      <= w_ferr_d;
`ifdef UART_RX_PARITY_EN
            r_perr      <= w_perr_d;
            r_perr_pend <= w_perr_pend_d;
`endif
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_tick_d  = (r_tick == TICK_LAST) ? '0 : r_tick + TW'(1);
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_data_d  = r_data;
        w_valid_d = 1'b0;
        w_ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_d      = 1'b0;
        w_perr_pend_d = r_perr_pend;
        w_good        = !r_perr_pend;
`else
        w_good        = 1'b1;
`endif

        unique case (r_state)
            IDLE: begin
                w_tick_d = '0;
                if (w_rxs == START_BIT) w_state_d = START;
            end
            START: begin
                // Mid-start check rejects glitches shorter than half a bit.
                if (r_tick == TICK_HALF) begin
                    if (w_rxs != START_BIT) begin
                        w_state_d = IDLE;
                    end else begin
                        w_state_d = DATA;
                        w_tick_d  = '0;
                        w_bit_d   = '0;
                    end
                end
            end
            DATA: begin
                if (r_tick == TICK_LAST) begin
                    w_shift_d = {w_rxs, r_shift[SIZE-1:1]};
                    if (r_bit == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        w_state_d = PARITY;
`else
                        w_state_d = STOP;
`endif
                    end else begin
                        w_bit_d = r_bit + BW'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (r_tick == TICK_LAST) begin
                    w_perr_pend_d = ((^r_shift) ^ w_rxs) != PARITY_ODD;
                    w_state_d     = STOP;
                end
            end
`endif
            STOP: begin
                if (r_tick == TICK_LAST) begin
                    if (w_rxs == STOP_BIT) begin
                        w_state_d = IDLE;
                        if (w_good) begin
                            w_data_d  = r_shift;
                            w_valid_d = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        w_perr_d = !w_good;
`endif
                    end else begin
                        // Framing error wins over parity; hold off until the line recovers.
                        w_ferr_d  = 1'b1;
                        w_state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (w_rxs == STOP_BIT) w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase
    end

    assign bus.RXDATA   = r_data;
    assign bus.RX_VALID = r_valid;
    assign bus.RX_FERR  = r_ferr;
    assign bus.RX_BUSY  = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.RX_PERR  = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames vs. a frame-level model.
// Honours UART_RX_PARITY_EN (adds parity bits and RX_PERR checks).
module tb_uart_rx;

    localparam int unsigned SIZE = 8;
    localparam int unsigned OVS  = 16;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned P = 1;
    localparam bit PARITY_ODD = 1'b0;
`else
    localparam int unsigned P = 0;
`endif
    // Pin fall to strobe: 3 sync/detect cycles, half-bit to start sample, then one bit per field.
    localparam int unsigned T_EV = 3 + OVS / 2 - 1 + (SIZE + 1 + P) * OVS + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned cyc = 0;
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    logic [SIZE-1:0] last_good = '0;

    int unsigned     exp_kind[$];
    int unsigned     exp_cyc[$];
    logic [SIZE-1:0] exp_data[$];
    int unsigned     obs_kind[$];
    int unsigned     obs_cyc[$];
    logic [SIZE-1:0] obs_data[$];

    uart_rx_if #(.SIZE(SIZE)) bus ();

    uart_rx #(
        .SIZE (SIZE),
`ifdef UART_RX_PARITY_EN
        .PARITY_ODD (PARITY_ODD),
`endif
        .OVS  (OVS)
    ) dut (
        .RXC (clk),
        .R   (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Monitor: record every strobe with its cycle and the word presented alongside it.
    always @(negedge clk) begin
        if (!rst) begin
            logic perr;
`ifdef UART_RX_PARITY_EN
            perr = bus.RX_PERR;
`else
            perr = 1'b0;
`endif
            check_eq("strobe_excl", 32'(bus.RX_VALID) + 32'(bus.RX_FERR) + 32'(perr) > 1, 0);
            if (bus.RX_BUSY) busy_cnt++;
            if (bus.RX_VALID) begin
                obs_kind.push_back(0); obs_cyc.push_back(cyc); obs_data.push_back(bus.RXDATA);
            end
            if (bus.RX_FERR) begin
                obs_kind.push_back(1); obs_cyc.push_back(cyc); obs_data.push_back(bus.RXDATA);
            end
            if (perr) begin
                obs_kind.push_back(2); obs_cyc.push_back(cyc); obs_data.push_back(bus.RXDATA);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Holds RXD at a level for n cycles; always returns 1 time unit after a posedge.
    task automatic drive(input logic level, input int unsigned n);
        bus.RXD = level;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int unsigned k, input int unsigned c, input logic [SIZE-1:0] d);
        exp_kind.push_back(k);
        exp_cyc.push_back(c);
        exp_data.push_back(d);
    endtask

    // Sends one frame and predicts its single strobe from the frame-level rules.
    task automatic send_frame(input logic [SIZE-1:0] d, input bit bad_stop, input bit bad_par,
                              input int unsigned hi_len, input int unsigned lo_len);
        int unsigned f;
        f = cyc;
        if (bad_stop) push_exp(1, f + T_EV, last_good);
        else if (bad_par) push_exp(2, f + T_EV, last_good);
        else begin
            push_exp(0, f + T_EV, d);
            last_good = d;
        end
        drive(1'b0, OVS);
        for (int k = 0; k < int'(SIZE); k++) drive(d[k], OVS);
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ PARITY_ODD ^ bad_par, OVS);
`endif
        if (bad_stop) drive(1'b0, lo_len);
        drive(1'b1, hi_len);
    endtask

    task automatic compare_events(input string tag);
        int n;
        drive(1'b1, 8);
        check_eq({tag, "_count"}, obs_kind.size(), exp_kind.size());
        n = (obs_kind.size() < exp_kind.size()) ? obs_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_kind"}, obs_kind[i], exp_kind[i]);
            check_eq({tag, "_cycle"}, obs_cyc[i], exp_cyc[i]);
            check_eq({tag, "_data"}, 32'(obs_data[i]), 32'(exp_data[i]));
        end
        exp_kind.delete(); exp_cyc.delete(); exp_data.delete();
        obs_kind.delete(); obs_cyc.delete(); obs_data.delete();
    endtask

    initial begin
        logic [SIZE-1:0] rd;
        logic [SIZE-1:0] d81;
        bit bs;
        bit bp;

        bus.RXD = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.RX_BUSY), 0);
        check_eq("rst_valid", 32'(bus.RX_VALID), 0);
        check_eq("rst_ferr", 32'(bus.RX_FERR), 0);
        check_eq("rst_data", 32'(bus.RXDATA), 0);
        rst = 1'b0;
        drive(1'b1, 5);

        // Nominal frame
        send_frame(8'hA5, 1'b0, 1'b0, OVS, 0);
        compare_events("nominal");

        // Glitch rejection
        busy_cnt = 0;
        drive(1'b0, 3);
        drive(1'b1, 40);
        check_eq("glitch_busy", busy_cnt, 8);
        compare_events("glitch");

        // Framing error with a long low stop: busy until the line has been seen high
        busy_cnt = 0;
        send_frame(8'h3C, 1'b1, 1'b0, 30, 40);
        check_eq("ferr_busy", busy_cnt, (1 + SIZE + P) * OVS + 40);
        compare_events("ferr");

        // Back-to-back, one-bit stops, no idle gap
        send_frame(8'h00, 1'b0, 1'b0, OVS, 0);
        send_frame(8'hFF, 1'b0, 1'b0, OVS, 0);
        compare_events("b2b");

        // Random frames
        for (int i = 0; i < 12; i++) begin
            rd = SIZE'($urandom);
            bs = ($urandom_range(0, 5) == 0);
            bp = (P == 1) && ($urandom_range(0, 3) == 0);
            send_frame(rd, bs, bp, OVS + $urandom_range(0, 20), 24 + $urandom_range(0, 16));
        end
        compare_events("random");

        // Reset in the middle of data bit 4 of 0x81
        send_frame(8'h5A, 1'b0, 1'b0, OVS, 0);
        compare_events("pre_reset");
        d81 = 8'h81;
        drive(1'b0, OVS);
        for (int k = 0; k < 4; k++) drive(d81[k], OVS);
        drive(d81[4], OVS / 2);
        rst = 1'b1;
        bus.RXD = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", 32'(bus.RX_BUSY), 0);
        check_eq("midrst_valid", 32'(bus.RX_VALID), 0);
        check_eq("midrst_ferr", 32'(bus.RX_FERR), 0);
        check_eq("midrst_data", 32'(bus.RXDATA), 0);
        rst = 1'b0;
        last_good = '0;
        exp_kind.delete(); exp_cyc.delete(); exp_data.delete();
        obs_kind.delete(); obs_cyc.delete(); obs_data.delete();
        drive(1'b1, 10);
        send_frame(8'h55, 1'b0, 1'b0, OVS, 0);
        compare_events("post_reset");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0, OVS, 0);
        compare_events("par_good");
        send_frame(8'h07, 1'b0, 1'b1, OVS, 0);
        compare_events("par_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the existing TX block.
- Accepts frames of 1 start bit (0), SIZE data bits LSB first, and 1 stop bit (1), with the line idle high.
- RXC runs at OVS times the bit rate. The block oversamples RXD, mid-bit samples each bit, and presents the parallel word with a one-cycle valid strobe.
- Sits between the RXD pin and the consuming logic, which has no backpressure.

Parameters:
- SIZE, 8, data bits per frame (4..16).
- OVS, 16, RXC cycles per bit; even, >= 4.

Ports:
- RXC  input  1  receive clock, OVS x bit rate; all logic on its posedge.
- R  input  1  reset, synchronous, active-high.
- RXD  input  1  serial line, asynchronous to RXC, idle high.
- RXDATA  output  SIZE  last received word; holds its value until the next frame completes.
- RX_VALID  output  1  one-cycle pulse when RXDATA is updated by a good frame.
- RX_BUSY  output  1  high whenever the state is not IDLE.
- RX_FERR  output  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Clock and reset: one clock, RXC. Reset R is synchronous and active-high.
- Reset values: state IDLE; RXDATA 0; RX_VALID, RX_BUSY and RX_FERR 0; both synchronizer flops 1; counters 0. Reset mid-frame aborts the frame with no strobe.
- Synchronizer: RXD passes through 2 flops; all decisions use the synchronized bit (rxs).
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rxs==0 moves to START and clears the tick counter.
  - Let S be the first START cycle. S equals the RXD pin-fall cycle + 3.
- START:
  - Sample at S+OVS/2-1.
  - rxs==1 is a false start: return to IDLE with no outputs.
  - rxs==0 moves to DATA, with bit index 0 and the tick counter cleared.
- DATA:
  - Bit k (k=0..SIZE-1) is sampled at S+OVS/2-1+(k+1)*OVS.
  - Each sample shifts into the MSB of a SIZE-bit shift register, shifting right, so the first bit lands in bit 0.
  - After bit SIZE-1, move to STOP.
- STOP:
  - Sample at S+OVS/2-1+(SIZE+1)*OVS.
  - rxs==1: in the next cycle RXDATA is loaded from the shift register, RX_VALID=1 and state=IDLE.
  - rxs==0: in the next cycle RX_FERR=1, RXDATA is unchanged and state=WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then go to IDLE. This prevents a break condition from re-triggering the receiver.
- RX_BUSY: combinational, (state != IDLE).
- Back-to-back frames: a new start edge is accepted from the first IDLE cycle after a stop.
  - This tolerates a sender stop bit as short as OVS/2+2 cycles.
- Tick counter: width $clog2(OVS); wraps to 0 at OVS-1.
- Bit index: width $clog2(SIZE)+1.
- Strobes: RX_VALID and RX_FERR are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds parameter PARITY_ODD (default 0 = even parity).
  - Adds output RX_PERR (1 bit).
  - Adds a PARITY state between DATA and STOP; the parity bit is sampled OVS after the last data bit, and the stop sample moves OVS later.
  - A parity mismatch with a good stop bit gives an RX_PERR pulse, no RX_VALID, and RXDATA unchanged.
  - A framing error takes precedence over a parity error.
- When undefined: no parity bit, no RX_PERR port, and no extra logic.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH, PARITY};
  - localparam START_BIT=1'b0 and STOP_BIT=1'b1;
  - function half_bit(OVS).
- One sub-module, uart_rx_sync: a 2-flop synchronizer with reset-to-1. It is instantiated once.

Test Plan:
- Nominal frame: SIZE=8, OVS=16, send 0xA5 (RXD low for 16 cycles, then 1,0,1,0,0,1,0,1, then stop high) -> RXDATA=0xA5 and RX_VALID pulses exactly at S+7+9*16+1; RX_FERR stays 0.
- Glitch rejection: RXD low for 3 cycles, then high -> returns to IDLE; RX_BUSY high for 8 cycles; no strobes.
- Framing error: send 0x3C with the stop bit held low for 40 cycles -> RX_FERR pulses once, RXDATA keeps its prior value, RX_BUSY stays high until RXD returns high, and no spurious restart occurs.
- Back-to-back: send 0x00 then 0xFF with a 1-bit stop and no idle gap -> two RX_VALID pulses 160 cycles apart, with RXDATA 0x00 then 0xFF.
- Reset mid-frame: assert R at data bit 4 of 0x81 -> the next cycle shows IDLE with all outputs 0; a following frame 0x55 is received correctly.
- Parity (with UART_RX_PARITY_EN, PARITY_ODD=0): 0x07 with parity bit 1 -> RX_VALID pulses; the same frame with parity bit 0 -> RX_PERR pulses and there is no RX_VALID.
